// File: rtl/watch_bcd_counter.sv
// Stopwatch time base: divides CLK to a 0.1 s tick and keeps an MM:SS.T count
// in five BCD digits, with one-cycle TICK and ROLLOVER pulses.
module watch_bcd_counter #(
    parameter int unsigned DIV = 1000000,
    parameter int unsigned PW  = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLKEN,
    input  logic       RST,
    output logic [3:0] TENTHS,
    output logic [3:0] SEC_LO,
    output logic [3:0] SEC_HI,
    output logic [3:0] MIN_LO,
    output logic [3:0] MIN_HI,
    output logic       TICK,
    output logic       ROLLOVER
);

    localparam logic [PW-1:0] LP_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_tenths, r_sec_lo, r_sec_hi, r_min_lo, r_min_hi;
    logic          r_tick, r_rollover;

    logic [PW-1:0] w_presc_nxt;
    logic [3:0]    w_tenths_nxt, w_sec_lo_nxt, w_sec_hi_nxt, w_min_lo_nxt, w_min_hi_nxt;
    logic          w_tick, w_c1, w_c2, w_c3, w_c4, w_c5;

    // ">=" rather than "==" so an out-of-range digit or prescaler self-recovers on the next tick
    always_comb begin
        w_tick      = CLKEN && (r_presc >= LP_LAST);
        w_presc_nxt = r_presc;
        if (CLKEN) begin
            w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        end

        w_c1 = w_tick && (r_tenths >= 4'd9);
        w_c2 = w_c1   && (r_sec_lo >= 4'd9);
        w_c3 = w_c2   && (r_sec_hi >= 4'd5);
        w_c4 = w_c3   && (r_min_lo >= 4'd9);
        w_c5 = w_c4   && (r_min_hi >= 4'd5);

        w_tenths_nxt = r_tenths;
        w_sec_lo_nxt = r_sec_lo;
        w_sec_hi_nxt = r_sec_hi;
        w_min_lo_nxt = r_min_lo;
        w_min_hi_nxt = r_min_hi;
        if (w_tick) w_tenths_nxt = w_c1 ? '0 : r_tenths + 4'd1;
        if (w_c1)   w_sec_lo_nxt = w_c2 ? '0 : r_sec_lo + 4'd1;
        if (w_c2)   w_sec_hi_nxt = w_c3 ? '0 : r_sec_hi + 4'd1;
        if (w_c3)   w_min_lo_nxt = w_c4 ? '0 : r_min_lo + 4'd1;
        if (w_c4)   w_min_hi_nxt = w_c5 ? '0 : r_min_hi + 4'd1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_presc    <= '0;
            r_tenths   <= '0;
            r_sec_lo   <= '0;
            r_sec_hi   <= '0;
            r_min_lo   <= '0;
            r_min_hi   <= '0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else if (RST) begin
            r_presc    <= '0;
            r_tenths   <= '0;
            r_sec_lo   <= '0;
            r_sec_hi   <= '0;
            r_min_lo   <= '0;
            r_min_hi   <= '0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_presc    <= w_presc_nxt;
            r_tenths   <= w_tenths_nxt;
            r_sec_lo   <= w_sec_lo_nxt;
            r_sec_hi   <= w_sec_hi_nxt;
            r_min_lo   <= w_min_lo_nxt;
            r_min_hi   <= w_min_hi_nxt;
            r_tick     <= w_tick;
            r_rollover <= w_c5;
        end
    end

    assign TENTHS   = r_tenths;
    assign SEC_LO   = r_sec_lo;
    assign SEC_HI   = r_sec_hi;
    assign MIN_LO   = r_min_lo;
    assign MIN_HI   = r_min_hi;
    assign TICK     = r_tick;
    assign ROLLOVER = r_rollover;

endmodule

// File: tb/tb_watch_bcd_counter.sv
// Self-checking bench for watch_bcd_counter (DIV=4): directed steps with random
// pause insertion, checked against an elapsed-tenths arithmetic model.
module tb_watch_bcd_counter;

    localparam int unsigned DIV = 4;
    localparam int unsigned PW  = 4;

    logic       CLK = 1'b0;
    logic       RESET, CLKEN, RST;
    logic [3:0] TENTHS, SEC_LO, SEC_HI, MIN_LO, MIN_HI;
    logic       TICK, ROLLOVER;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Model: elapsed tenths modulo one hour, plus enabled cycles into the current tick
    int unsigned m_n, m_p;
    logic        m_tick, m_roll;

    watch_bcd_counter #(.DIV(DIV), .PW(PW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CLKEN    (CLKEN),
        .RST      (RST),
        .TENTHS   (TENTHS),
        .SEC_LO   (SEC_LO),
        .SEC_HI   (SEC_HI),
        .MIN_LO   (MIN_LO),
        .MIN_HI   (MIN_HI),
        .TICK     (TICK),
        .ROLLOVER (ROLLOVER)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_n = 0; m_p = 0; m_tick = 1'b0; m_roll = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_tenths"}, TENTHS, m_n % 10);
        chk({tag, "_sec_lo"}, SEC_LO, (m_n / 10) % 10);
        chk({tag, "_sec_hi"}, SEC_HI, (m_n / 100) % 6);
        chk({tag, "_min_lo"}, MIN_LO, (m_n / 600) % 10);
        chk({tag, "_min_hi"}, MIN_HI, m_n / 6000);
        chk({tag, "_tick"},   TICK,   m_tick);
        chk({tag, "_roll"},   ROLLOVER, m_roll);
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        if (RST) begin
            model_clear();
        end else if (CLKEN) begin
            if (m_p == DIV - 1) begin
                m_p    = 0;
                m_tick = 1'b1;
                m_roll = (m_n == 35999);
                m_n    = (m_n + 1) % 36000;
            end else begin
                m_p++;
                m_tick = 1'b0;
                m_roll = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
            m_roll = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) step(tag);
    endtask

    // Runs n enabled cycles, randomly inserting paused cycles in between
    task automatic run_enabled_random_pauses(input int unsigned n, input string tag);
        int unsigned done;
        done = 0;
        while (done < n) begin
            CLKEN = ($urandom_range(0, 7) != 0);
            step(tag);
            if (CLKEN) done++;
        end
        CLKEN = 1'b1;
    endtask

    task automatic clear_with_rst();
        RST = 1'b1;
        step("rst");
        RST = 1'b0;
    endtask

    int unsigned tick_cnt, first_tick, last_tick, gap_errs;

    initial begin
        RESET = 1'b1; CLKEN = 1'b0; RST = 1'b0;
        model_clear();
        #12;
        check_outputs("reset");
        RESET = 1'b0;

        // 1: 40 enabled cycles give ten evenly spaced ticks and 00:01.0
        CLKEN = 1'b1;
        tick_cnt = 0; first_tick = 0; last_tick = 0; gap_errs = 0;
        for (int unsigned c = 1; c <= 40; c++) begin
            step("t1");
            if (TICK === 1'b1) begin
                if (tick_cnt == 0) first_tick = c;
                else if (c - last_tick != DIV) gap_errs++;
                last_tick = c;
                tick_cnt++;
            end
        end
        chk("t1_ticks", tick_cnt, 10);
        chk("t1_first", first_tick, DIV);
        chk("t1_gaps",  gap_errs, 0);
        chk("t1_disp", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h00010);

        // 2: pause at 00:00.3 + 2 cycles, resume takes two more cycles to tick
        clear_with_rst();
        run(3 * DIV + 2, "t2_count");
        CLKEN = 1'b0;
        run(17, "t2_pause");
        chk("t2_hold", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h00003);
        CLKEN = 1'b1;
        step("t2_res1");
        chk("t2_notick", TICK, 1'b0);
        step("t2_res2");
        chk("t2_tick", TICK, 1'b1);
        chk("t2_disp", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h00004);

        // 3: RST wins over CLKEN at 00:12.7 with prescaler at DIV-1
        clear_with_rst();
        run_enabled_random_pauses(127 * DIV + DIV - 1, "t3_count");
        chk("t3_pre", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h00127);
        RST = 1'b1; CLKEN = 1'b1;
        step("t3_rst");
        chk("t3_disp", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h00000);
        chk("t3_tick", TICK, 1'b0);
        RST = 1'b0;
        run(DIV - 1, "t3_after");
        chk("t3_presc0", TICK, 1'b0);
        step("t3_first");
        chk("t3_first_tick", TICK, 1'b1);

        // 4: cascade 09:59.9 -> 10:00.0
        clear_with_rst();
        run(5999 * DIV, "t4_count");
        chk("t4_pre", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h09599);
        run(DIV, "t4_step");
        chk("t4_disp", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h10000);
        chk("t4_tick", TICK, 1'b1);
        chk("t4_roll", ROLLOVER, 1'b0);

        // 5: wrap; digits preloaded to 59:59.0 while paused, prescaler is 0 here
        CLKEN = 1'b0;
        force dut.r_tenths = 4'd0;
        force dut.r_sec_lo = 4'd9;
        force dut.r_sec_hi = 4'd5;
        force dut.r_min_lo = 4'd9;
        force dut.r_min_hi = 4'd5;
        m_n = 35990;
        step("t5_load");
        release dut.r_tenths;
        release dut.r_sec_lo;
        release dut.r_sec_hi;
        release dut.r_min_lo;
        release dut.r_min_hi;
        step("t5_kept");
        CLKEN = 1'b1;
        run(9 * DIV, "t5_count");
        chk("t5_pre", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h59599);
        run(DIV, "t5_wrap");
        chk("t5_disp", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h00000);
        chk("t5_roll", ROLLOVER, 1'b1);
        chk("t5_tick", TICK, 1'b1);
        step("t5_next");
        chk("t5_roll_once", ROLLOVER, 1'b0);
        run(DIV, "t5_cont");

        // 6: async reset between edges at 03:21.4
        clear_with_rst();
        run(2014 * DIV, "t6_count");
        chk("t6_pre", {MIN_HI, MIN_LO, SEC_HI, SEC_LO, TENTHS}, 20'h03214);
        #2;
        RESET = 1'b1;
        #1;
        model_clear();
        check_outputs("t6_async");
        #1;
        RESET = 1'b0;
        run(2 * DIV, "t6_after");

        // Illegal tenths value: a tick forces it to 0 and carries
        clear_with_rst();
        CLKEN = 1'b0;
        force dut.r_tenths = 4'd12;
        @(posedge CLK); #1;
        release dut.r_tenths;
        CLKEN = 1'b1;
        repeat (DIV) begin
            @(posedge CLK); #1;
        end
        chk("ill_tenths", TENTHS, 4'd0);
        chk("ill_carry",  SEC_LO, 4'd1);
        chk("ill_tick",   TICK,   1'b1);
        m_n = 10; m_p = 0; m_tick = 1'b1; m_roll = 1'b0;
        run(2 * DIV, "ill_cont");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
